binary_divider_seq: RTL and testbench

Sequential restoring divider for the calculator datapath. It is the inverse of the 2-bit multiplier: it takes a 4-bit dividend and a 2-bit divisor, and produces the quotient and remainder, one quotient bit per clock. Results are registered and drive two active-low 7-segment digit outputs, using the same segment encoding as the existing display path.

---
 rtl/binary_divider_seq_pkg.sv | 28 ++
 rtl/binary_divider_seq_seg7_digit.sv | 21 ++
 rtl/binary_divider_seq.sv | 140 ++++++++++++++
 tb/tb_binary_divider_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/binary_divider_seq_pkg.sv
// Shared types and 7-segment constants for the sequential divider and the display path.
// Segment bit order is {g,f,e,d,c,b,a}, active low.
package binary_divider_seq_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Entry n is the pattern for value n; 10..15 are blank on this display.
  localparam logic [15:0][6:0] SEG_DIGITS = {
    SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
    7'b0010000,   // 9
    7'b0000000,   // 8
    7'b1111000,   // 7
    7'b0000010,   // 6
    7'b0010010,   // 5
    7'b0011001,   // 4
    7'b0110000,   // 3
    7'b0100100,   // 2
    7'b1111001,   // 1
    7'b1000000    // 0
  };

endpackage

// File: rtl/binary_divider_seq_seg7_digit.sv
// Single 7-segment digit decoder with dash and blank overrides.
// Dash takes priority over blank.
module seg7_digit
  import binary_divider_seq_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DIGITS[value];
    if (dash) begin
      seg = SEG_DASH;
    end else if (blank) begin
      seg = SEG_BLANK;
    end
  end

endmodule

// File: rtl/binary_divider_seq.sv
// Sequential restoring divider: DW-bit dividend by VW-bit divisor, one quotient bit per clock,
// with registered results driving two active-low 7-segment digits.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | waiting for start; divide-by-zero is answered from here
//   ST_CALC | shifting/subtracting, cnt_q counts remaining iterations down
module binary_divider_seq
  import binary_divider_seq_pkg::*;
#(
  parameter int DW = 4,
  parameter int VW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero,
  output logic [6:0]    seg_q,
  output logic [6:0]    seg_r
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  state_t         state, state_nx;
  logic [DW-1:0]  shift_q;
  logic [VW-1:0]  dvsr_q;
  logic [VW:0]    part_q;
  logic [CW-1:0]  cnt_q;

  logic           accept;
  logic           accept_zero;
  logic           last_iter;

  logic [VW+1:0]  diff;
  logic           borrow;
  logic [VW:0]    part_nx;
  logic [DW-1:0]  shift_nx;

  assign busy = (state == ST_CALC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    accept      = 1'b0;
    accept_zero = 1'b0;
    last_iter   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            accept_zero = 1'b1;
          end else begin
            accept   = 1'b1;
            state_nx = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (cnt_q == '0) begin
          last_iter = 1'b1;
          state_nx  = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Trial subtraction one bit wider than the partial so its MSB is the borrow.
  always_comb begin
    diff     = {part_q, shift_q[DW-1]} - {2'b00, dvsr_q};
    borrow   = diff[VW+1];
    part_nx  = borrow ? {part_q[VW-1:0], shift_q[DW-1]} : diff[VW:0];
    shift_nx = {shift_q[DW-2:0], ~borrow};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q     <= '0;
      dvsr_q      <= '0;
      part_q      <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        shift_q <= dividend;
        dvsr_q  <= divisor;
        part_q  <= '0;
        cnt_q   <= CW'(DW - 1);
      end else if (busy) begin
        shift_q <= shift_nx;
        part_q  <= part_nx;
        cnt_q   <= cnt_q - CW'(1);
      end
      if (accept_zero) begin
        quotient    <= '1;
        remainder   <= '0;
        div_by_zero <= 1'b1;
        done        <= 1'b1;
      end
      if (last_iter) begin
        quotient    <= shift_nx;
        remainder   <= part_nx[VW-1:0];
        div_by_zero <= 1'b0;
        done        <= 1'b1;
      end
    end
  end

  seg7_digit u_seg_q (
    .value (4'(quotient)),
    .blank (1'b0),
    .dash  (div_by_zero),
    .seg   (seg_q)
  );

  seg7_digit u_seg_r (
    .value (4'(remainder)),
    .blank (div_by_zero),
    .dash  (1'b0),
    .seg   (seg_r)
  );

endmodule

// File: tb/tb_binary_divider_seq.sv
// Self-checking bench for binary_divider_seq: directed cases, exhaustive sweep and random ops
// compared every cycle against an arithmetic model of the results and their timing.
module tb_binary_divider_seq;

  localparam int DW = 4;
  localparam int VW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          busy, done, div_by_zero;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic [6:0]    seg_q, seg_r;

  binary_divider_seq #(.DW(DW), .VW(VW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .seg_q       (seg_q),
    .seg_r       (seg_r)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  int exp_busy = 0, exp_done = 0, exp_q = 0, exp_r = 0, exp_dz = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [6:0] model_seg(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, exp_busy);
      check("done", done, exp_done);
      check("quotient", quotient, exp_q);
      check("remainder", remainder, exp_r);
      check("div_by_zero", div_by_zero, exp_dz);
      check("seg_q", seg_q, exp_dz ? 7'b0111111 : model_seg(exp_q));
      check("seg_r", seg_r, exp_dz ? 7'b1111111 : model_seg(exp_r));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    exp_done = 0;
  endtask

  task automatic launch(input int a, input int b);
    dividend = DW'(a);
    divisor  = VW'(b);
    start    = 1'b1;
    tick();
    start    = 1'b0;
    if (b == 0) begin
      exp_q    = (1 << DW) - 1;
      exp_r    = 0;
      exp_dz   = 1;
      exp_done = 1;
    end else begin
      exp_busy = 1;
    end
  endtask

  task automatic complete(input int a, input int b);
    if (b != 0) begin
      repeat (DW) tick();
      exp_busy = 0;
      exp_done = 1;
      exp_q    = a / b;
      exp_r    = a % b;
      exp_dz   = 0;
    end
  endtask

  task automatic set_reset_expect();
    exp_busy = 0;
    exp_done = 0;
    exp_q    = 0;
    exp_r    = 0;
    exp_dz   = 0;
  endtask

  initial begin
    #1;
    rst_n = 1'b0;
    set_reset_expect();
    chk_en = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_seg_q", seg_q, 7'b1000000);
    check("reset_seg_r", seg_r, 7'b1000000);
    rst_n = 1'b1;
    tick();

    // 9 / 3
    launch(9, 3);
    complete(9, 3);
    check("lit_9div3_q", quotient, 3);
    check("lit_9div3_r", remainder, 0);
    check("lit_9div3_seg_q", seg_q, 7'b0110000);
    check("lit_9div3_seg_r", seg_r, 7'b1000000);
    tick();

    // 15 / 2
    launch(15, 2);
    complete(15, 2);
    check("lit_15div2_q", quotient, 7);
    check("lit_15div2_seg_q", seg_q, 7'b1111000);
    check("lit_15div2_seg_r", seg_r, 7'b1111001);
    tick();

    // 6 / 0 then 6 / 1 back-to-back
    launch(6, 0);
    check("lit_6div0_q", quotient, 15);
    check("lit_6div0_seg_q", seg_q, 7'b0111111);
    check("lit_6div0_seg_r", seg_r, 7'b1111111);
    launch(6, 1);
    complete(6, 1);
    check("lit_6div1_q", quotient, 6);
    check("lit_6div1_dz", div_by_zero, 0);
    tick();

    // start while busy is ignored; start in done cycle is accepted
    launch(9, 2);
    dividend = 4'd3;
    divisor  = 2'd3;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (DW - 2) tick();
    tick();
    exp_busy = 0;
    exp_done = 1;
    exp_q    = 4;
    exp_r    = 1;
    exp_dz   = 0;
    check("lit_9div2_q", quotient, 4);
    launch(3, 3);
    complete(3, 3);
    check("lit_3div3_q", quotient, 1);
    tick();

    // reset two cycles into CALC
    launch(9, 3);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    set_reset_expect();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    launch(8, 3);
    complete(8, 3);
    check("lit_8div3_q", quotient, 2);
    check("lit_8div3_r", remainder, 2);
    tick();

    // exhaustive sweep, back-to-back
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 4; b++) begin
        launch(a, b);
        complete(a, b);
        if (a / b >= 10) check("sweep_blank_seg_q", seg_q, 7'b1111111);
      end
    end
    tick();

    // random operations with random idle gaps
    for (int i = 0; i < 200; i++) begin
      int a, b;
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 3);
      launch(a, b);
      complete(a, b);
      repeat ($urandom_range(0, 2)) tick();
    end
    tick();
    tick();

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
